// File: rtl/alu_control_muldiv.sv
// EX-stage ALU control decode plus an iterative multiply/divide sequencer
// that owns the architectural HI/LO registers and raises a pipeline stall.
module alu_control_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    input  logic [1:0]        aluOp,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] opA,
    input  logic [DATA_W-1:0] opB,
    output logic [3:0]        aluControl,
    output logic              stall,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] mfOut,
    output logic              divZero
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_MTLO = 6'b010011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W:0]   acc;
    logic [DATA_W-1:0] q, mag_a, mag_b;
    logic              neg_q, neg_r, is_div;

    logic              r_type, is_md_f, is_mfmt_f, sgn_f, div_f, op_zero;
    logic              a_neg, b_neg, busy, accept, last_step;
    logic [DATA_W-1:0] abs_a, abs_b, quo_fix, rem_fix, dz_hi;
    logic [DATA_W:0]   mul_sum, mul_sel, div_shift, div_diff;
    logic [2*DATA_W-1:0] prod, prod_fix;

    // mult/multu/div/divu are 0110xx, mfhi/mthi/mflo/mtlo are 0100xx.
    assign r_type    = (aluOp == 2'b10);
    assign is_md_f   = (funct[5:2] == 4'b0110);
    assign is_mfmt_f = (funct[5:2] == 4'b0100);
    assign sgn_f     = ~funct[0];
    assign div_f     = funct[1];
    assign op_zero   = (opB == '0);

    assign a_neg = sgn_f & opA[DATA_W-1];
    assign b_neg = sgn_f & opB[DATA_W-1];
    assign abs_a = a_neg ? -opA : opA;
    assign abs_b = b_neg ? -opB : opB;

    assign busy      = (state != IDLE);
    assign accept    = issue && !busy && r_type && is_md_f;
    assign stall     = busy && issue && r_type && (is_md_f || is_mfmt_f);
    assign last_step = (cnt == CNT_W'(DATA_W - 1));

    assign mfOut = (funct == F_MFHI) ? hi : (funct == F_MFLO) ? lo : '0;

    always_comb begin
        aluControl = 4'b0000;
        case (aluOp)
            2'b00: aluControl = 4'b0010;
            2'b01: aluControl = 4'b0110;
            2'b11: aluControl = 4'b0001;
            default: begin
                case (funct)
                    6'b100000, 6'b100001: aluControl = 4'b0010;
                    6'b100010, 6'b100011: aluControl = 4'b0110;
                    6'b100100:            aluControl = 4'b0000;
                    6'b100101:            aluControl = 4'b0001;
                    6'b100110:            aluControl = 4'b0011;
                    6'b100111:            aluControl = 4'b1100;
                    6'b101010:            aluControl = 4'b0111;
                    6'b101011:            aluControl = 4'b1000;
                    default:              aluControl = 4'b0000;
                endcase
            end
        endcase
    end

    // Multiply: acc holds the running upper half, q the multiplier shifting out.
    assign mul_sum  = acc + {1'b0, mag_a};
    assign mul_sel  = q[0] ? mul_sum : acc;
    // Divide: q holds the dividend shifting in as quotient bits shift out.
    assign div_shift = {acc[DATA_W-1:0], q[DATA_W-1]};
    assign div_diff  = div_shift - {1'b0, mag_b};

    assign prod     = {acc[DATA_W-1:0], q};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -q : q;
    assign rem_fix  = neg_r ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    assign dz_hi    = neg_r ? -mag_a : mag_a;

    always_comb begin
        // NOTE: default assigned first so no path leaves state_nx unassigned (no latch).
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = !div_f ? MUL : (op_zero ? FIX : DIV);
            MUL:  if (last_step) state_nx = FIX;
            DIV:  if (last_step) state_nx = FIX;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments for all clocked state to avoid ordering races.
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            acc     <= '0;
            q       <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            is_div  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            divZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt     <= '0;
                        acc     <= '0;
                        q       <= div_f ? abs_a : abs_b;
                        mag_a   <= abs_a;
                        mag_b   <= abs_b;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        is_div  <= div_f;
                        divZero <= div_f && op_zero;
                    end else if (issue && r_type && funct == F_MTHI) begin
                        hi <= opA;
                    end else if (issue && r_type && funct == F_MTLO) begin
                        lo <= opA;
                    end
                end
                MUL: begin
                    acc <= {1'b0, mul_sel[DATA_W:1]};
                    q   <= {mul_sel[0], q[DATA_W-1:1]};
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    if (!div_diff[DATA_W]) begin
                        acc <= div_diff;
                        q   <= {q[DATA_W-2:0], 1'b1};
                    end else begin
                        acc <= div_shift;
                        q   <= {q[DATA_W-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (!is_div) begin
                        {hi, lo} <= prod_fix;
                    end else if (divZero) begin
                        hi <= dz_hi;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_control_muldiv.sv
// Randomized bench for alu_control_muldiv: a transaction-level model computes
// HI/LO with plain arithmetic and is compared against the DUT every cycle.
module tb_alu_control_muldiv;
    localparam int W  = 32;
    localparam int W8 = 8;

    logic clk = 1'b0;
    logic reset;
    logic issue;
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [W-1:0] opa, opb;
    logic [3:0] alu_ctl;
    logic stall, div_zero;
    logic [W-1:0] hi, lo, mf_out;

    logic issue8;
    logic [1:0] aluop8;
    logic [5:0] funct8;
    logic [W8-1:0] opa8, opb8;
    logic [3:0] alu_ctl8;
    logic stall8, div_zero8;
    logic [W8-1:0] hi8, lo8, mf_out8;

    alu_control_muldiv #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .issue(issue), .aluOp(aluop), .funct(funct),
        .opA(opa), .opB(opb), .aluControl(alu_ctl), .stall(stall), .hi(hi),
        .lo(lo), .mfOut(mf_out), .divZero(div_zero)
    );

    alu_control_muldiv #(.DATA_W(W8)) dut8 (
        .clk(clk), .reset(reset), .issue(issue8), .aluOp(aluop8), .funct(funct8),
        .opA(opa8), .opB(opb8), .aluControl(alu_ctl8), .stall(stall8), .hi(hi8),
        .lo(lo8), .mfOut(mf_out8), .divZero(div_zero8)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_md(input logic [5:0] f);
        return f inside {6'h18, 6'h19, 6'h1A, 6'h1B};
    endfunction

    function automatic logic is_mf(input logic [5:0] f);
        return f inside {6'h10, 6'h11, 6'h12, 6'h13};
    endfunction

    function automatic logic [3:0] exp_ctl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 4'h2;
        if (op == 2'b01) return 4'h6;
        if (op == 2'b11) return 4'h1;
        case (f)
            6'h20, 6'h21: return 4'h2;
            6'h22, 6'h23: return 4'h6;
            6'h24: return 4'h0;
            6'h25: return 4'h1;
            6'h26: return 4'h3;
            6'h27: return 4'hC;
            6'h2A: return 4'h7;
            6'h2B: return 4'h8;
            default: return 4'h0;
        endcase
    endfunction

    // Returns {hi, lo} for a w-bit mul/div using 64-bit host arithmetic.
    function automatic logic [127:0] compute(input int w, input logic [5:0] f,
                                             input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask, ua, ub, p, qv, rv;
        longint sa, sb;
        mask = (64'd1 << w) - 64'd1;
        ua = a & mask;
        ub = b & mask;
        sa = $signed(ua << (64 - w)) >>> (64 - w);
        sb = $signed(ub << (64 - w)) >>> (64 - w);
        case (f)
            6'h18: begin p = sa * sb; return {(p >> w) & mask, p & mask}; end
            6'h19: begin p = ua * ub; return {(p >> w) & mask, p & mask}; end
            6'h1A, 6'h1B: begin
                if (ub == 64'd0) return {ua, mask};
                if (f == 6'h1A) begin qv = sa / sb; rv = sa % sb; end
                else begin qv = ua / ub; rv = ua % ub; end
                return {rv & mask, qv & mask};
            end
            default: return 128'd0;
        endcase
    endfunction

    // Transaction model of the 32-bit instance: result known at accept, published
    // after the architectural latency.
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic         m_dz = 1'b0;
    int           m_rem = 0;
    logic [127:0] m_res = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi  <= '0;
            m_lo  <= '0;
            m_dz  <= 1'b0;
            m_rem <= 0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_hi <= m_res[64 +: W];
                m_lo <= m_res[0 +: W];
            end
        end else if (issue && aluop == 2'b10) begin
            if (is_md(funct)) begin
                m_res <= compute(W, funct, {32'd0, opa}, {32'd0, opb});
                m_dz  <= funct[1] && (opb == '0);
                m_rem <= (funct[1] && (opb == '0)) ? 1 : W + 1;
            end else if (funct == 6'h11) begin
                m_hi <= opa;
            end else if (funct == 6'h13) begin
                m_lo <= opa;
            end
        end
    end

    function automatic logic exp_stall();
        return (m_rem > 0) && issue && (aluop == 2'b10) && (is_md(funct) || is_mf(funct));
    endfunction

    always @(negedge clk) begin
        check("aluControl", alu_ctl, exp_ctl(aluop, funct));
        check("stall", stall, exp_stall());
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        check("divZero", div_zero, m_dz);
        if (!exp_stall())
            check("mfOut", mf_out, (funct == 6'h10) ? m_hi : (funct == 6'h12) ? m_lo : '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        issue = 1'b1;
        aluop = 2'b10;
        funct = f;
        opa = a;
        opb = b;
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom % 6)
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return W'($urandom % 16);
            default: return W'($urandom);
        endcase
    endfunction

    logic [11:0] dec_tab [15] = '{
        {2'b00, 6'h00, 4'h2}, {2'b01, 6'h00, 4'h6}, {2'b11, 6'h00, 4'h1},
        {2'b10, 6'h20, 4'h2}, {2'b10, 6'h21, 4'h2}, {2'b10, 6'h22, 4'h6},
        {2'b10, 6'h23, 4'h6}, {2'b10, 6'h24, 4'h0}, {2'b10, 6'h25, 4'h1},
        {2'b10, 6'h26, 4'h3}, {2'b10, 6'h27, 4'hC}, {2'b10, 6'h2A, 4'h7},
        {2'b10, 6'h2B, 4'h8}, {2'b10, 6'h3F, 4'h0}, {2'b00, 6'h3F, 4'h2}
    };
    logic [5:0] funct_pool [12] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11,
                                    6'h12, 6'h13, 6'h20, 6'h22, 6'h2A, 6'h3F};

    initial begin
        logic [127:0] r8;
        logic [5:0]   f8;
        logic [7:0]   a8, b8;
        reset = 1'b1;
        issue = 1'b0; aluop = 2'b00; funct = 6'h00; opa = '0; opb = '0;
        issue8 = 1'b0; aluop8 = 2'b00; funct8 = 6'h00; opa8 = '0; opb8 = '0;
        repeat (2) tick();
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset divZero", div_zero, 0);
        #2 reset = 1'b0;
        tick();

        // Reset in the middle of a multiply, with a stalled mfhi waiting.
        drive(6'h18, 123, 456);
        tick();
        funct = 6'h10;
        repeat (10) tick();
        check("mid-mul stall", stall, 1);
        reset = 1'b1;
        #1;
        check("async reset stall", stall, 0);
        check("async reset hi", hi, 0);
        check("async reset lo", lo, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(6'h18, 3, 4);
        tick();
        issue = 1'b0;
        repeat (W + 1) tick();
        check("post-reset mult lo", lo, 12);
        check("post-reset mult hi", hi, 0);

        // Decode sweep.
        foreach (dec_tab[i]) begin
            aluop = dec_tab[i][11:10];
            funct = dec_tab[i][9:4];
            #1;
            check("decode", alu_ctl, dec_tab[i][3:0]);
        end

        // Signed multiply 7 * -3, stall only for mul/div-class instructions.
        drive(6'h18, 7, 32'hFFFF_FFFD);
        tick();
        issue = 1'b0; funct = 6'h20;
        repeat (4) tick();
        issue = 1'b1; funct = 6'h10;
        tick();
        check("mfhi stall E5", stall, 1);
        repeat (27) tick();
        check("mfhi stall E32", stall, 1);
        check("hi not partial E32", hi, 0);
        funct = 6'h20;
        #1;
        check("add not stalled", stall, 0);
        tick();
        issue = 1'b0;
        check("mult hi", hi, 32'hFFFF_FFFF);
        check("mult lo", lo, 32'hFFFF_FFEB);

        // Back-to-back divides: the second waits stalled until after FIX.
        drive(6'h1A, 32'hFFFF_FFF9, 2);
        tick();
        drive(6'h1B, 100, 7);
        repeat (32) tick();
        check("divu held stall", stall, 1);
        tick();
        check("div lo", lo, 32'hFFFF_FFFD);
        check("div hi", hi, 32'hFFFF_FFFF);
        check("stall after fix", stall, 0);
        tick();
        check("divu accepted", stall, 1);
        issue = 1'b0;
        repeat (W + 1) tick();
        check("divu lo", lo, 14);
        check("divu hi", hi, 2);

        // Divide by zero, then a valid divide clears divZero.
        drive(6'h1A, 32'h12, 0);
        tick();
        check("divZero set E0", div_zero, 1);
        drive(6'h1A, 10, 3);
        tick();
        check("div0 hi", hi, 32'h12);
        check("div0 lo", lo, 32'hFFFF_FFFF);
        tick();
        check("divZero cleared", div_zero, 0);
        issue = 1'b0;
        repeat (W + 1) tick();
        check("div 10/3 lo", lo, 3);
        check("div 10/3 hi", hi, 1);

        // mthi then mflo/mfhi in IDLE.
        drive(6'h11, 32'hA5A5_A5A5, 0);
        tick();
        funct = 6'h12;
        #1;
        check("mflo", mf_out, 3);
        check("mflo stall", stall, 0);
        funct = 6'h10;
        #1;
        check("mfhi", mf_out, 32'hA5A5_A5A5);
        issue = 1'b0;

        // 8-bit instance: signed 0x80 * 0x80.
        issue8 = 1'b1; aluop8 = 2'b10; funct8 = 6'h18; opa8 = 8'h80; opb8 = 8'h80;
        tick();
        issue8 = 1'b0;
        repeat (W8) tick();
        check("w8 hi not partial", hi8, 0);
        check("w8 lo not partial", lo8, 0);
        tick();
        check("w8 mult hi", hi8, 8'h40);
        check("w8 mult lo", lo8, 8'h00);
        for (int i = 0; i < 24; i++) begin
            f8 = 6'h18 + 6'($urandom % 4);
            a8 = ($urandom % 5 == 0) ? 8'h80 : 8'($urandom);
            b8 = ($urandom % 5 == 0) ? 8'h00 : (($urandom % 4 == 0) ? 8'hFF : 8'($urandom));
            r8 = compute(W8, f8, {56'd0, a8}, {56'd0, b8});
            issue8 = 1'b1; funct8 = f8; opa8 = a8; opb8 = b8;
            tick();
            issue8 = 1'b0;
            repeat (W8 + 1) tick();
            check("w8 rand hi", hi8, r8[64 +: 8]);
            check("w8 rand lo", lo8, r8[0 +: 8]);
            check("w8 rand divZero", div_zero8, f8[1] && (b8 == 8'h00));
        end

        // Randomized traffic on the 32-bit instance against the model.
        for (int i = 0; i < 3000; i++) begin
            issue = ($urandom % 4) != 0;
            aluop = ($urandom % 8 == 0) ? 2'($urandom) : 2'b10;
            funct = funct_pool[$urandom % 12];
            opa   = rnd_op();
            opb   = rnd_op();
            tick();
        end
        issue = 1'b0;
        repeat (W + 4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_control_muldiv.md
Name: alu_control_muldiv

Overview:
Next-generation EX-stage ALU control for the MIPS core.
- Decodes aluOp/funct into the 4-bit ALU control code, with an extended R-type set.
- Adds a parametrised iterative multiply/divide sequencer with architectural HI/LO registers, mfhi/mflo readout, mthi/mtlo writes and a pipeline stall output.
- Sits beside the ALU; the hazard unit ORs `stall` into its freeze signal.

Parameters:
DATA_W, 32, operand/HI/LO width; legal range 4..64.
CNT_W, $clog2(DATA_W+1), iteration counter width; derived, not overridden.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
issue  in  1  EX-stage instruction valid this cycle
aluOp  in  2  main-control ALU opcode
funct  in  6  instruction funct field
opA  in  DATA_W  rs value (dividend / multiplicand / mthi-mtlo source)
opB  in  DATA_W  rt value (divisor / multiplier)
aluControl  out  4  ALU operation code (combinational)
stall  out  1  freeze the pipeline this cycle (combinational)
hi  out  DATA_W  HI register
lo  out  DATA_W  LO register
mfOut  out  DATA_W  HI if funct=010000, LO if funct=010010, else 0 (combinational)
divZero  out  1  sticky; last divide had a zero divisor

Behaviour:
- Decode, pure combinational:
  - aluOp 00 -> 0010.
  - aluOp 01 -> 0110.
  - aluOp 11 -> 0001.
  - aluOp 10, by funct: 100000/100001 -> 0010; 100010/100011 -> 0110; 100100 -> 0000; 100101 -> 0001; 100110 -> 0011; 100111 -> 1100; 101010 -> 0111; 101011 -> 1000; any other -> 0000.
- Mul/div functs, recognised only with aluOp=10:
  - mult 011000, multu 011001, div 011010, divu 011011.
  - mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
- Reset, asynchronous: state=IDLE, hi=0, lo=0, divZero=0, counter=0. Any in-flight operation is discarded and HI/LO are not written.
- FSM states: IDLE, MUL, DIV, FIX.
- Accept rule: at an edge where issue=1, state=IDLE and funct is a mul/div op.
  - Operands are latched as magnitudes. Signed ops take the two's-complement absolute value; unsigned ops use the raw value.
  - The result sign is latched. Product is negative iff the operand signs differ. Quotient is negative iff the signs differ. Remainder takes the dividend's sign.
  - Next state: MUL for mult/multu; DIV for div/divu with opB!=0; FIX for divide by zero.
  - divZero is loaded with (divide && opB==0) at the accept edge.
- MUL and DIV: one bit per cycle for exactly DATA_W edges. MUL is shift-add; DIV is restoring. Then FIX.
- FIX: one edge. Applies sign correction, writes HI/LO, returns to IDLE.
  - mult/multu: {hi,lo} = 2*DATA_W-bit product.
  - div/divu: lo = quotient, hi = remainder.
  - Zero divisor: hi = opA as latched, lo = all ones.
  - Signed most-negative / -1: lo = most-negative value (wrap), hi = 0.
- Latency: accept edge E0, HI/LO written at E(DATA_W+1). Zero-divisor case writes at E1. The earliest next accept is the edge after the FIX edge.
- busy = (state != IDLE).
- stall = busy && issue && aluOp==10 && funct in {mul/div, mf*, mt*}. Other instructions are not stalled while the engine runs.
- A stalled instruction is not accepted. Upstream holds issue/funct/operands stable.
- mthi/mtlo with issue=1 in IDLE write opA into hi/lo at that edge. divZero is unchanged.
- mfOut is valid whenever stall=0. HI/LO are never partially visible.

Test Plan:
1. Reset asserted mid-MUL (cycle 10 of 32) -> hi=lo=0, divZero=0, stall=0 immediately (async); the next mult is accepted normally.
2. Decode sweep: aluOp 00/01/11 and all R-type functs, including 100111 and 101011 -> 0010/0110/0001 and the listed codes; undefined funct 111111 -> 0000.
3. mult with opA=7, opB=0xFFFFFFFD (-3) -> at E33, hi=0xFFFFFFFF, lo=0xFFFFFFEB. stall=1 for a mfhi issued at E5..E32; an add issued meanwhile gets stall=0.
4. div with -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with 100/7 -> lo=14, hi=2. Back-to-back: the second is accepted the edge after the first's FIX.
5. div with opA=0x12, opB=0 -> divZero=1 at E0, hi=0x12, lo=0xFFFFFFFF at E1. A following valid div clears divZero at its accept edge.
6. mthi 0xA5A5A5A5, then mflo/mfhi in IDLE -> mfOut=lo then 0xA5A5A5A5 with stall=0. Repeat with DATA_W=8: mult 0x80 x 0x80 signed -> hi=0x40, lo=0x00 at E9.
